// File: rtl/led_pio_scheduler_if.sv
// Avalon-MM write-only bus between the LED scheduler (master) and the PIO s1 slave.
interface led_pio_if;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport master (
    output m_address, m_chipselect, m_write_n, m_writedata,
    input  m_waitrequest
  );

  modport slave (
    input  m_address, m_chipselect, m_write_n, m_writedata,
    output m_waitrequest
  );
endinterface

// File: rtl/led_pio_scheduler.sv
// Shares the 8-bit LED PIO between a bar-graph audio meter (rate-limited, peak-hold)
// and Nios software, with round-robin arbitration, software lock and redundant-write suppression.
module led_pio_scheduler #(
  parameter int REFRESH_DIV = 50000,
  parameter int DECAY_TICKS = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_meter_valid,
  input  logic [7:0] i_meter_level,
  input  logic       i_sw_valid,
  input  logic [7:0] i_sw_pattern,
  output logic       o_sw_ready,
  input  logic       i_sw_lock,
  led_pio_if.master  bus,
  output logic [7:0] o_cur_pattern,
  output logic       o_grant_src,
  output logic       o_busy
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DECAY_TICKS + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  function automatic logic [7:0] meter_pattern(input logic [3:0] n, input logic [3:0] pk);
    return 8'((9'd1 << n) - 9'd1) | ((pk != 4'd0) ? 8'(9'd1 << (pk - 4'd1)) : 8'd0);
  endfunction

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_dcnt;
  logic [3:0]    r_lvl_n, r_peak, r_peak_last;
  logic          r_meter_pend, r_sw_pend, r_tick_seen;
  logic [7:0]    r_sw_pat, r_wr_pat, r_cur_pattern;
  logic          r_wr_src, r_grant_src, r_cs, r_wn, r_busy;

  logic          w_tick, w_sw_elig, w_mt_elig;
  logic          w_grant, w_pick_sw, w_meter_grant, w_suppress;
  logic [3:0]    w_n;
  logic [7:0]    w_meter_pat, w_grant_pat;

  assign w_n         = 4'((9'(i_meter_level) + 9'd31) >> 5);
  assign w_tick      = (r_timer == TW'(REFRESH_DIV - 1));
  assign w_meter_pat = meter_pattern(r_lvl_n, r_peak);
  assign w_sw_elig   = r_sw_pend;
  assign w_mt_elig   = (r_meter_pend | (r_peak != r_peak_last)) & r_tick_seen & ~i_sw_lock;

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    w_grant   = 1'b0;
    w_pick_sw = 1'b0;
    if ((r_state == S_IDLE) && (w_sw_elig || w_mt_elig)) begin
      w_grant = 1'b1;
      if (w_sw_elig && w_mt_elig) begin
        w_pick_sw = ~r_grant_src;
      end else begin
        w_pick_sw = w_sw_elig;
      end
    end else begin
      w_grant   = 1'b0;
      w_pick_sw = 1'b0;
    end
    w_grant_pat   = w_pick_sw ? r_sw_pat : w_meter_pat;
    w_meter_grant = w_grant & ~w_pick_sw;
    w_suppress    = (w_grant_pat == r_cur_pattern);
  end

  // Free-running refresh timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Latest bar length and peak-hold with tick-based decay; a peak load beats a decay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl_n <= 4'd0;
      r_peak  <= 4'd0;
      r_dcnt  <= '0;
    end else begin
      if (i_meter_valid) r_lvl_n <= w_n;
      if (i_meter_valid && (w_n >= r_peak)) begin
        r_peak <= w_n;
        r_dcnt <= '0;
      end else if (w_tick) begin
        if (r_dcnt == DW'(DECAY_TICKS - 1)) begin
          r_dcnt <= '0;
          if (r_peak != 4'd0) r_peak <= r_peak - 4'd1;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end
  end

  // Request bookkeeping and the IDLE/WRITE bus FSM with registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_meter_pend  <= 1'b0;
      r_sw_pend     <= 1'b0;
      r_tick_seen   <= 1'b0;
      r_sw_pat      <= 8'd0;
      r_wr_pat      <= 8'd0;
      r_wr_src      <= 1'b0;
      r_cur_pattern <= 8'd0;
      r_grant_src   <= 1'b0;
      r_peak_last   <= 4'd0;
      r_cs          <= 1'b0;
      r_wn          <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      // Clearing on a meter grant wins so a tick landing on the grant cycle cannot allow a second write.
      if (w_meter_grant)  r_tick_seen <= 1'b0;
      else if (w_tick)    r_tick_seen <= 1'b1;
      if (i_meter_valid)      r_meter_pend <= 1'b1;
      else if (w_meter_grant) r_meter_pend <= 1'b0;
      if (w_meter_grant)  r_peak_last <= r_peak;
      if (i_sw_valid && !r_sw_pend) begin
        r_sw_pend <= 1'b1;
        r_sw_pat  <= i_sw_pattern;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_grant_src <= w_pick_sw;
            if (w_suppress) begin
              if (w_pick_sw) r_sw_pend <= 1'b0;
            end else begin
              r_state  <= S_WRITE;
              r_wr_pat <= w_grant_pat;
              r_wr_src <= w_pick_sw;
              r_cs     <= 1'b1;
              r_wn     <= 1'b0;
              r_busy   <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!bus.m_waitrequest) begin
            r_state       <= S_IDLE;
            r_cs          <= 1'b0;
            r_wn          <= 1'b1;
            r_busy        <= 1'b0;
            r_cur_pattern <= r_wr_pat;
            if (r_wr_src) r_sw_pend <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cs    <= 1'b0;
          r_wn    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_address   = 2'd0;
  assign bus.m_chipselect = r_cs;
  assign bus.m_write_n   = r_wn;
  assign bus.m_writedata = {24'd0, r_wr_pat};
  assign o_cur_pattern   = r_cur_pattern;
  assign o_grant_src     = r_grant_src;
  assign o_busy          = r_busy;
  assign o_sw_ready      = ~r_sw_pend;

endmodule

// File: tb/tb_led_pio_scheduler.sv
// Self-checking bench for led_pio_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the LED-sharing rules.
module tb_led_pio_scheduler;
  localparam int DIV = 4;
  localparam int DT  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic meter_valid = 1'b0;
  logic [7:0] meter_level = 8'd0;
  logic sw_valid = 1'b0;
  logic [7:0] sw_pattern = 8'd0;
  logic sw_ready, sw_lock = 1'b0;
  logic [7:0] cur_pattern;
  logic grant_src, busy;

  led_pio_if bus ();

  led_pio_scheduler #(.REFRESH_DIV(DIV), .DECAY_TICKS(DT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_meter_valid(meter_valid), .i_meter_level(meter_level),
    .i_sw_valid(sw_valid), .i_sw_pattern(sw_pattern), .o_sw_ready(sw_ready),
    .i_sw_lock(sw_lock), .bus(bus),
    .o_cur_pattern(cur_pattern), .o_grant_src(grant_src), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, in plain integers.
  int m_tmr, m_lvl, m_peak, m_dcnt, m_peak_last;
  bit m_mpend, m_spend, m_tseen, m_inwr, m_wsrc, m_gsrc;
  logic [7:0] m_spat, m_wpat, m_cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int leds_for(input int level);
    return (level + 31) / 32;
  endfunction

  function automatic logic [7:0] meter_img(input int n, input int pk);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) if (i < n || i == pk - 1) p[i] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_tmr = 0; m_lvl = 0; m_peak = 0; m_dcnt = 0; m_peak_last = 0;
    m_mpend = 0; m_spend = 0; m_tseen = 0; m_inwr = 0; m_wsrc = 0; m_gsrc = 0;
    m_spat = 8'h00; m_wpat = 8'h00; m_cur = 8'h00;
  endtask

  task automatic step();
    bit tick, e_sw, e_mt, g, pick_sw, mg;
    int n, o_peak;
    logic [7:0] gpat;
    tick    = (m_tmr == DIV - 1);
    n       = leds_for(int'(meter_level));
    e_sw    = m_spend;
    e_mt    = (m_mpend || m_peak != m_peak_last) && m_tseen && !sw_lock;
    g       = !m_inwr && (e_sw || e_mt);
    pick_sw = (e_sw && e_mt) ? !m_gsrc : e_sw;
    mg      = g && !pick_sw;
    gpat    = pick_sw ? m_spat : meter_img(m_lvl, m_peak);
    o_peak  = m_peak;
    m_tmr = tick ? 0 : m_tmr + 1;
    if (meter_valid) m_lvl = n;
    if (meter_valid && n >= o_peak) begin
      m_peak = n; m_dcnt = 0;
    end else if (tick) begin
      if (m_dcnt == DT - 1) begin
        m_dcnt = 0;
        if (m_peak > 0) m_peak--;
      end else m_dcnt++;
    end
    if (mg) m_peak_last = o_peak;
    m_tseen = mg ? 1'b0 : (tick ? 1'b1 : m_tseen);
    m_mpend = meter_valid ? 1'b1 : (mg ? 1'b0 : m_mpend);
    if (sw_valid && !m_spend) begin
      m_spend = 1; m_spat = sw_pattern;
    end
    if (m_inwr) begin
      if (!bus.m_waitrequest) begin
        m_inwr = 0; m_cur = m_wpat;
        if (m_wsrc) m_spend = 0;
      end
    end else if (g) begin
      m_gsrc = pick_sw;
      if (gpat == m_cur) begin
        if (pick_sw) m_spend = 0;
      end else begin
        m_inwr = 1; m_wpat = gpat; m_wsrc = pick_sw;
      end
    end
    @(posedge clk);
    #1;
    chk("cs",   bus.m_chipselect, m_inwr);
    chk("wn",   bus.m_write_n, !m_inwr);
    chk("wd",   bus.m_writedata, {24'd0, m_wpat});
    chk("addr", bus.m_address, 2'd0);
    chk("cur",  cur_pattern, m_cur);
    chk("gsrc", grant_src, m_gsrc);
    chk("busy", busy, m_inwr);
    chk("rdy",  sw_ready, !m_spend);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_cs(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.m_chipselect; i++) step();
    chk(tag, bus.m_chipselect, 1'b1);
  endtask

  initial begin
    int hi, nwr;
    bit done, cs_d;
    logic [7:0] p, prev;
    bus.m_waitrequest = 1'b0;
    do_reset();

    // Reset values
    chk("rst_cs", bus.m_chipselect, 1'b0);
    chk("rst_wn", bus.m_write_n, 1'b1);
    chk("rst_wd", bus.m_writedata, 32'h0);
    chk("rst_cur", cur_pattern, 8'h00);
    chk("rst_gsrc", grant_src, 1'b0);
    chk("rst_rdy", sw_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // Software write of A5: chipselect one cycle after acceptance, one cycle long
    sw_valid = 1'b1; sw_pattern = 8'hA5;
    step();
    sw_valid = 1'b0;
    chk("sw_rdy_low", sw_ready, 1'b0);
    step();
    chk("sw_cs", bus.m_chipselect, 1'b1);
    chk("sw_wd", bus.m_writedata, 32'h000000A5);
    chk("sw_gsrc", grant_src, 1'b1);
    step();
    chk("sw_cs_end", bus.m_chipselect, 1'b0);
    chk("sw_cur", cur_pattern, 8'hA5);
    chk("sw_rdy_back", sw_ready, 1'b1);

    // Meter level 100 -> 0F; repeating it is suppressed
    meter_valid = 1'b1; meter_level = 8'd100;
    step();
    meter_valid = 1'b0;
    wait_cs("meter100_timeout", 2 * DIV + 4);
    chk("meter100_wd", bus.m_writedata, 32'h0000000F);
    step();
    chk("meter100_cur", cur_pattern, 8'h0F);
    meter_valid = 1'b1;
    step();
    meter_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("meter100_quiet", bus.m_chipselect, 1'b0);
    end

    // Level 255 then 0: FF, then a single peak LED walking down to 00
    meter_valid = 1'b1; meter_level = 8'd255;
    step();
    meter_valid = 1'b0;
    wait_cs("meter255_timeout", 2 * DIV + 4);
    chk("meter255_wd", bus.m_writedata, 32'h000000FF);
    step();
    meter_valid = 1'b1; meter_level = 8'd0;
    step();
    meter_valid = 1'b0;
    nwr = 0; prev = 8'h00; done = 1'b0; cs_d = bus.m_chipselect;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (bus.m_chipselect && !cs_d) begin
        p = bus.m_writedata[7:0];
        if (nwr == 0) chk("decay_first", (p == 8'h80) || (p == 8'h40), 1'b1);
        else          chk("decay_step", p, prev >> 1);
        prev = p; nwr++;
        if (p == 8'h00) done = 1'b1;
      end
      cs_d = bus.m_chipselect;
    end
    chk("decay_done", done, 1'b1);
    step();
    chk("decay_cur", cur_pattern, 8'h00);

    // Lock holds the meter; both eligible with grant_src=0 -> software first, then meter
    chk("rr_gsrc_pre", grant_src, 1'b0);
    sw_lock = 1'b1; meter_valid = 1'b1; meter_level = 8'd50;
    step();
    meter_valid = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      step();
      chk("lock_quiet", bus.m_chipselect, 1'b0);
    end
    sw_valid = 1'b1; sw_pattern = 8'h3C;
    step();
    sw_valid = 1'b0; sw_lock = 1'b0;
    step();
    chk("rr_sw_cs", bus.m_chipselect, 1'b1);
    chk("rr_sw_wd", bus.m_writedata, 32'h0000003C);
    chk("rr_sw_gsrc", grant_src, 1'b1);
    step();
    wait_cs("rr_meter_timeout", 2 * DIV + 4);
    chk("rr_meter_wd", bus.m_writedata, 32'h00000003);
    chk("rr_meter_gsrc", grant_src, 1'b0);
    step();

    // Waitrequest for three cycles stretches chipselect to four
    bus.m_waitrequest = 1'b1;
    sw_valid = 1'b1; sw_pattern = 8'h5A;
    step();
    sw_valid = 1'b0;
    wait_cs("wait_timeout", 6);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.m_chipselect) break;
      hi++;
      chk("wait_wd", bus.m_writedata, 32'h0000005A);
      bus.m_waitrequest = (i < 3);
      step();
    end
    chk("wait_cs_len", hi, 4);
    chk("wait_cur", cur_pattern, 8'h5A);
    bus.m_waitrequest = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      meter_valid = ($urandom_range(0, 3) == 0);
      meter_level = 8'($urandom_range(0, 255));
      sw_valid    = ($urandom_range(0, 4) == 0);
      sw_pattern  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 24) == 0) sw_lock = ~sw_lock;
      bus.m_waitrequest = ($urandom_range(0, 2) == 0);
      step();
    end
    meter_valid = 1'b0; sw_valid = 1'b0; sw_lock = 1'b0; bus.m_waitrequest = 1'b0;

    // Asynchronous reset in the middle of a stalled write
    do_reset();
    bus.m_waitrequest = 1'b1;
    sw_valid = 1'b1; sw_pattern = 8'h77;
    step();
    sw_valid = 1'b0;
    step();
    chk("abort_pre_cs", bus.m_chipselect, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_cs", bus.m_chipselect, 1'b0);
    chk("abort_wn", bus.m_write_n, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_cur", cur_pattern, 8'h00);
    bus.m_waitrequest = 1'b0;
    do_reset();
    step();
    chk("post_abort_cur", cur_pattern, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
